// File: rtl/aes_pkg.sv
// Shared AES types, FSM states and byte-level helpers (S-box lookup, GF(2^8) doubling, MixColumns).
package aes_pkg;

    localparam int Nb = 4;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t xtimes(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t sbox(input byte_t b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic word_t mixColumn(input word_t col);
        byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtimes(a0) ^ xtimes(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtimes(a1) ^ xtimes(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtimes(a2) ^ xtimes(a3) ^ a3,
                xtimes(a0) ^ a0 ^ a1 ^ a2 ^ xtimes(a3)};
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when final), AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  block_t i_state,
    input  block_t i_roundKey,
    input  logic   i_final,
    output block_t o_state
);

    byte_t  w_shifted [16];
    block_t w_mixed;

    // Byte 4*c+r of the state sits in row r, column c; row r rotates left by r columns.
    for (genvar c = 0; c < Nb; c++) begin : g_col
        word_t w_col;
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shifted[4*c+r] = sbox(i_state[127-8*(4*((c+r)%4)+r) -: 8]);
        end
        assign w_col = {w_shifted[4*c], w_shifted[4*c+1], w_shifted[4*c+2], w_shifted[4*c+3]};
        assign w_mixed[127-32*c -: 32] = i_final ? w_col : mixColumn(w_col);
    end

    assign o_state = w_mixed ^ i_roundKey;

endmodule

// File: rtl/keyexpansion.sv
// Combinational AES key schedule: expands an Nk-word key into Nr+1 round keys, round 0 = raw key.
module keyexpansion
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [Nk*32-1:0] i_key,
    output block_t           o_roundKeys [Nr+1]
);

    localparam int NumWords = Nb * (Nr + 1);

    function automatic word_t subWord(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic byte_t rcon(input int n);
        byte_t r;
        r = 8'h01;
        for (int j = 1; j < n; j++) r = xtimes(r);
        return r;
    endfunction

    // Each word lives in its own generate scope so the chain is not one self-referencing array.
    for (genvar i = 0; i < NumWords; i++) begin : g_word
        word_t w_word;
        if (i < Nk) begin : g_key
            assign w_word = i_key[Nk*32-1-32*i -: 32];
        end else if (i % Nk == 0) begin : g_rot
            assign w_word = g_word[i-Nk].w_word
                          ^ subWord({g_word[i-1].w_word[23:0], g_word[i-1].w_word[31:24]})
                          ^ {rcon(i / Nk), 24'h000000};
        end else if (Nk > 6 && i % Nk == 4) begin : g_sub
            assign w_word = g_word[i-Nk].w_word ^ subWord(g_word[i-1].w_word);
        end else begin : g_xor
            assign w_word = g_word[i-Nk].w_word ^ g_word[i-1].w_word;
        end
    end

    for (genvar r = 0; r <= Nr; r++) begin : g_round
        assign o_roundKeys[r] = {g_word[4*r].w_word, g_word[4*r+1].w_word,
                                 g_word[4*r+2].w_word, g_word[4*r+3].w_word};
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES forward cipher, one round per clock, valid/ready on both sides.
// Define AES_TRACE_EN to print the state after every round in simulation.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in,
    input  logic [Nk*32-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out
);

    localparam logic [3:0] LAST_ROUND = 4'(Nr);

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_ctr;
    block_t           r_block;
    logic [Nk*32-1:0] r_key;
    block_t           r_out;
    block_t           w_roundKeys [Nr+1];
    block_t           w_roundOut;
    logic             w_final;
    logic             w_accept;

    keyexpansion #(.Nk(Nk), .Nr(Nr)) u_keyexp (
        .i_key      (r_key),
        .o_roundKeys(w_roundKeys)
    );

    aes_round u_round (
        .i_state   (r_block),
        .i_roundKey(w_roundKeys[r_ctr]),
        .i_final   (w_final),
        .o_state   (w_roundOut)
    );

    assign w_final = (r_ctr == LAST_ROUND);
    assign out     = r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_final) w_nextState = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Round 0 AddRoundKey uses the raw input key; the counter parks at Nr while the result waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctr   <= 4'd0;
            r_block <= '0;
            r_key   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_block <= in ^ key[Nk*32-1 -: 128];
                        r_key   <= key;
                        r_ctr   <= 4'd1;
                    end
                end
                RUN: begin
                    r_block <= w_roundOut;
                    if (w_final) r_out <= w_roundOut;
                    else         r_ctr <= r_ctr + 4'd1;
                end
                DONE: begin
                    if (out_ready) r_ctr <= 4'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef AES_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && r_state == RUN) begin
            $display("Round %0d: %h", r_ctr, w_roundOut);
            if (w_final) $display("Ciphertext: %h", w_roundOut);
        end
    end
`endif

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: FIPS-197 vectors for AES-128/192/256, handshake corners,
// async reset mid-job and a decrypt-model round trip over random blocks.
module tb_aes_cipher_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid  [3];
    logic         inReady  [3];
    logic         outValid [3];
    logic         outReady [3];
    logic [127:0] inBlk    [3];
    logic [127:0] outBlk   [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sboxM    [256];
    logic [7:0]   invSboxM [256];
    logic [127:0] rk       [11];

    typedef struct {
        int           sel;
        int           nr;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [4];

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_cipher_iter #(.Nk(4), .Nr(10)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .in(inBlk[0]),
        .key(key128), .out_valid(outValid[0]), .out_ready(outReady[0]), .out(outBlk[0])
    );

    aes_cipher_iter #(.Nk(6), .Nr(12)) dut192 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .in(inBlk[1]),
        .key(key192), .out_valid(outValid[1]), .out_ready(outReady[1]), .out(outBlk[1])
    );

    aes_cipher_iter #(.Nk(8), .Nr(14)) dut256 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]), .in(inBlk[2]),
        .key(key256), .out_valid(outValid[2]), .out_ready(outReady[2]), .out(outBlk[2])
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map, independent of the RTL table.
    task automatic buildSbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sboxM[x] = s;
            invSboxM[s] = 8'(x);
        end
    endtask

    task automatic expandKey(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [79:0] rc;
        rc = 80'h01020408102040801b36;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) begin
                w[i] = k[127-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sboxM[t[31:24]], sboxM[t[23:16]], sboxM[t[15:8]], sboxM[t[7:0]]}
                        ^ {rc[79-8*(i/4-1) -: 8], 24'h0};
                end
                w[i] = w[i-4] ^ t;
            end
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] invCipher(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        blk = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            for (int j = 0; j < 16; j++) s[j] = blk[127-8*j -: 8];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = invSboxM[s[4*((c-q+4)%4)+q]];
            for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = t[j];
            blk = blk ^ rk[r];
            if (r > 0) begin
                for (int j = 0; j < 16; j++) s[j] = blk[127-8*j -: 8];
                for (int c = 0; c < 4; c++) begin
                    t[4*c]   = gmul(s[4*c], 8'h0e) ^ gmul(s[4*c+1], 8'h0b) ^ gmul(s[4*c+2], 8'h0d) ^ gmul(s[4*c+3], 8'h09);
                    t[4*c+1] = gmul(s[4*c], 8'h09) ^ gmul(s[4*c+1], 8'h0e) ^ gmul(s[4*c+2], 8'h0b) ^ gmul(s[4*c+3], 8'h0d);
                    t[4*c+2] = gmul(s[4*c], 8'h0d) ^ gmul(s[4*c+1], 8'h09) ^ gmul(s[4*c+2], 8'h0e) ^ gmul(s[4*c+3], 8'h0b);
                    t[4*c+3] = gmul(s[4*c], 8'h0b) ^ gmul(s[4*c+1], 8'h0d) ^ gmul(s[4*c+2], 8'h09) ^ gmul(s[4*c+3], 8'h0e);
                end
                for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = t[j];
            end
        end
        return blk;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic setKey(input int sel, input logic [255:0] k);
        case (sel)
            0:       key128 = k[255:128];
            1:       key192 = k[255:64];
            default: key256 = k;
        endcase
    endtask

    // Offers one job, scrambles the inputs right after the accepting edge, then counts edges to out_valid.
    task automatic applyStimulus(input int sel, input logic [255:0] k, input logic [127:0] pt,
                                 output logic [127:0] ct, output int lat);
        outReady[sel] = 1'b0;
        inBlk[sel]    = pt;
        setKey(sel, k);
        inValid[sel]  = 1'b1;
        tick();
        inValid[sel]  = 1'b0;
        inBlk[sel]    = ~pt;
        setKey(sel, ~k);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!outValid[sel] && lat < 40);
        ct = outBlk[sel];
    endtask

    task automatic drainOutput(input int sel);
        outReady[sel] = 1'b1;
        tick();
        outReady[sel] = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!outValid[0] && lat < 40);
    endtask

    initial begin
        logic [127:0] ct, held, pt;
        logic [127:0] k;
        int lat, stable, quiet;

        vecs[0] = '{sel: 0, nr: 10, key: KEY_B, pt: PT_B, ct: CT_B};
        vecs[1] = '{sel: 0, nr: 10, key: {KEY_C[255:128], 128'h0}, pt: PT_C, ct: CT_C1};
        vecs[2] = '{sel: 1, nr: 12, key: {KEY_C[255:64], 64'h0}, pt: PT_C, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[3] = '{sel: 2, nr: 14, key: KEY_C, pt: PT_C, ct: 128'h8ea2b7ca516745bfeafc49904b496089};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid[i]  = 1'b0;
            outReady[i] = 1'b0;
            inBlk[i]    = '0;
        end
        key128 = '0;
        key192 = '0;
        key256 = '0;
        buildSbox();
        #12;
        checkOutput("reset in_ready", 128'(inReady[0]), 128'd1);
        checkOutput("reset out_valid", 128'(outValid[0]), 128'd0);
        checkOutput("reset out", outBlk[0], 128'd0);
        rst = 1'b0;

        $display("[TB] FIPS-197 vectors");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].sel, vecs[v].key, vecs[v].pt, ct, lat);
            checkOutput($sformatf("vec%0d ciphertext", v), ct, vecs[v].ct);
            checkOutput($sformatf("vec%0d latency", v), 128'(lat), 128'(vecs[v].nr));
            drainOutput(vecs[v].sel);
        end

        $display("[TB] backpressure");
        inBlk[0] = PT_B;
        key128   = KEY_B[255:128];
        inValid[0] = 1'b1;
        tick();
        inBlk[0] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        key128   = 128'h0;
        waitValid(lat);
        checkOutput("bp latency", 128'(lat), 128'd10);
        held = outBlk[0];
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (outBlk[0] !== held || inReady[0] !== 1'b0 || outValid[0] !== 1'b1) stable = 0;
        end
        checkOutput("bp held stable", 128'(stable), 128'd1);
        checkOutput("bp ciphertext", held, CT_B);
        inValid[0] = 1'b0;
        drainOutput(0);
        checkOutput("bp release out_valid", 128'(outValid[0]), 128'd0);
        checkOutput("bp release in_ready", 128'(inReady[0]), 128'd1);
        checkOutput("bp out kept", outBlk[0], CT_B);

        $display("[TB] back-to-back");
        outReady[0] = 1'b1;
        inBlk[0] = PT_B;
        key128   = KEY_B[255:128];
        inValid[0] = 1'b1;
        tick();
        inValid[0] = 1'b0;
        waitValid(lat);
        checkOutput("b2b job1 latency", 128'(lat), 128'd10);
        checkOutput("b2b job1 ciphertext", outBlk[0], CT_B);
        inBlk[0] = PT_C;
        key128   = KEY_C[255:128];
        inValid[0] = 1'b1;
        tick();
        checkOutput("b2b idle after handoff", 128'(inReady[0]), 128'd1);
        tick();
        checkOutput("b2b accepted 2nd edge", 128'(inReady[0]), 128'd0);
        inValid[0] = 1'b0;
        waitValid(lat);
        checkOutput("b2b job2 latency", 128'(lat), 128'd10);
        checkOutput("b2b job2 ciphertext", outBlk[0], CT_C1);
        inBlk[0] = PT_B;
        key128   = KEY_B[255:128];
        inValid[0] = 1'b1;
        tick();
        tick();
        inValid[0] = 1'b0;
        waitValid(lat);
        checkOutput("b2b job3 ciphertext", outBlk[0], CT_B);
        tick();
        outReady[0] = 1'b0;

        $display("[TB] async reset mid-run");
        inBlk[0] = PT_C;
        key128   = KEY_C[255:128];
        inValid[0] = 1'b1;
        tick();
        inValid[0] = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst mid out_valid", 128'(outValid[0]), 128'd0);
        checkOutput("rst mid out", outBlk[0], 128'd0);
        checkOutput("rst mid in_ready", 128'(inReady[0]), 128'd1);
        #1 rst = 1'b0;
        quiet = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (outValid[0] !== 1'b0) quiet = 0;
        end
        checkOutput("rst no emission", 128'(quiet), 128'd1);
        applyStimulus(0, KEY_B, PT_B, ct, lat);
        checkOutput("rst next job", ct, CT_B);
        drainOutput(0);

        $display("[TB] random round trip");
        for (int n = 0; n < 100; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(0, {k, 128'h0}, pt, ct, lat);
            drainOutput(0);
            expandKey(k);
            checkOutput($sformatf("roundtrip %0d", n), invCipher(ct), pt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
